serial_program_loader: RTL and testbench

//  Upstream feeder for the 8-bit CPU's programming port. Receives program bytes on a
//  2-wire serial link (ser_clk/ser_data, MSB first) and buffers them in a small FIFO.

---
 rtl/serial_program_loader.sv | 152 +++++++++++++++
 tb/tb_serial_program_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_program_loader.sv
// Serial-to-parallel program feeder for the 8-bit CPU programming port.
// Buffers host bytes in a small FIFO and paces them out on the CPU's ready/done handshake.
module serial_program_loader #(
    parameter int BYTE_COUNT  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          ser_clk,
    input  logic                          ser_data,
    input  logic                          cpu_ready,
    input  logic                          cpu_done,
    output logic [7:0]                    prog_data,
    output logic                          programming,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [$clog2(BYTE_COUNT):0]   bytes_sent,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BYTE_COUNT) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, RUN} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, sdat_sync;
    logic                   sclk_q;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;
    logic                   rx_edge, push;
    logic [7:0]             rx_byte;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   empty, full, pop, push_ok, pop_ok, ovf_evt;

    logic                   ready_q, und_evt, clear;
    logic [BW-1:0]          sent_n;

    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
        return (v == BW'(BYTE_COUNT)) ? v : v + BW'(1);
    endfunction

    // Receiver: synchronise, detect rising ser_clk, assemble MSB-first bytes
    assign rx_edge = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
    assign rx_byte = {shift_reg[6:0], sdat_sync[SYNC_STAGES-1]};
    assign push    = rx_edge && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            sdat_sync <= '0;
            sclk_q    <= 1'b0;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ser_clk};
            sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], ser_data};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            if (rx_edge) begin
                shift_reg <= rx_byte;
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    // FIFO: a pop in the same cycle frees a slot, so push-while-full still lands
    assign empty   = (fifo_count == '0);
    assign full    = (fifo_count == CW'(FIFO_DEPTH));
    assign pop     = (state == LOAD) && ready_q && !cpu_ready && (bytes_sent != BW'(BYTE_COUNT));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign ovf_evt = push && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Session control
    assign und_evt = (state == LOAD) && cpu_ready && !ready_q && empty;
    assign sent_n  = pop_ok ? sat_inc(bytes_sent) : bytes_sent;

    always_comb begin
        state_n = state;
        clear   = 1'b0;
        case (state)
            IDLE, RUN: begin
                if (start) begin
                    state_n = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (cpu_done)
                    state_n = RUN;
                else if (sent_n == BW'(BYTE_COUNT))
                    state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cpu_done)
                    state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            bytes_sent <= '0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            ready_q    <= cpu_ready;
            bytes_sent <= clear ? '0 : sent_n;
            overflow   <= (overflow & ~clear) | ovf_evt;
            underrun   <= (underrun & ~clear) | und_evt;
        end
    end

    assign busy        = (state == LOAD) || (state == WAIT_DONE);
    assign programming = busy;
    assign prog_data   = ((state == LOAD) && !empty) ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_serial_program_loader.sv
// Bench for serial_program_loader: directed scenarios plus random operation mix,
// checked against a transaction-level model (byte queue, session mode, counters).
module tb_serial_program_loader;

    logic       clk = 1'b0;
    logic       rst_n, start, ser_clk, ser_data, cpu_ready, cpu_done;
    logic [7:0] prog_data;
    logic       programming, busy, overflow, underrun;
    logic [2:0] fifo_count;
    logic [4:0] bytes_sent;

    serial_program_loader #(.BYTE_COUNT(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ser_clk(ser_clk), .ser_data(ser_data),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .prog_data(prog_data),
        .programming(programming), .busy(busy), .fifo_count(fifo_count),
        .bytes_sent(bytes_sent), .overflow(overflow), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_LOAD, M_WAIT, M_RUN} md_t;

    logic [7:0] m_q[$];
    md_t        m_mode;
    int         m_sent;
    bit         m_ovf, m_und;
    int         n_total = 0;
    int         n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mode = M_IDLE;
        m_sent = 0;
        m_ovf  = 0;
        m_und  = 0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_prog;
        bit         exp_busy;
        exp_prog = (m_mode == M_LOAD && m_q.size() > 0) ? m_q[0] : 8'h00;
        exp_busy = (m_mode == M_LOAD || m_mode == M_WAIT);
        chk({tag, ".prog"},  prog_data,   exp_prog);
        chk({tag, ".pgm"},   programming, exp_busy);
        chk({tag, ".busy"},  busy,        exp_busy);
        chk({tag, ".count"}, fifo_count,  m_q.size());
        chk({tag, ".sent"},  bytes_sent,  m_sent);
        chk({tag, ".ovf"},   overflow,    m_ovf);
        chk({tag, ".und"},   underrun,    m_und);
    endtask

    // One byte, MSB first; lat=1 also checks fifo_count timing around the 8th edge.
    task automatic send_byte(input logic [7:0] b, input bit lat);
        int old;
        for (int i = 7; i >= 0; i--) begin
            ser_data = b[i];
            ser_clk  = 1'b0;
            tick(3);
            ser_clk = 1'b1;
            if (i == 0 && lat) begin
                old = fifo_count;
                tick(2);
                chk("lat.pre", fifo_count, old);
                tick(1);
                chk("lat.post", fifo_count, old + 1);
            end else begin
                tick(3);
            end
        end
        ser_clk = 1'b0;
        tick(3);
        if (m_q.size() < 4) m_q.push_back(b);
        else m_ovf = 1;
    endtask

    // With cpu_ready already high and the FIFO full, land the push and the pop on one edge.
    task automatic send_pop(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            ser_data = b[i];
            ser_clk  = 1'b0;
            tick(3);
            ser_clk = 1'b1;
            if (i == 0) begin
                tick(2);
                cpu_ready = 1'b0;
                tick(1);
            end else begin
                tick(3);
            end
        end
        void'(m_q.pop_front());
        m_sent++;
        m_q.push_back(b);
        ser_clk = 1'b0;
        tick(3);
    endtask

    task automatic consume();
        cpu_ready = 1'b1;
        if (m_mode == M_LOAD && m_q.size() == 0) m_und = 1;
        tick(2);
        check_all("cons.hi");
        cpu_ready = 1'b0;
        tick(2);
        if (m_mode == M_LOAD && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_sent++;
            if (m_sent == 16) m_mode = M_WAIT;
        end
        check_all("cons.lo");
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_RUN) begin
            m_mode = M_LOAD;
            m_sent = 0;
            m_ovf  = 0;
            m_und  = 0;
        end
        check_all("start");
    endtask

    task automatic do_done();
        cpu_done = 1'b1;
        tick(1);
        cpu_done = 1'b0;
        if (m_mode == M_LOAD || m_mode == M_WAIT) m_mode = M_RUN;
        check_all("done");
    endtask

    initial begin
        int nxt;
        rst_n = 1'b0; start = 1'b0; ser_clk = 1'b0; ser_data = 1'b0;
        cpu_ready = 1'b0; cpu_done = 1'b0;
        model_reset();
        tick(2);
        check_all("rst");
        rst_n = 1'b1;
        tick(2);

        // Reset mid-byte while loading discards the partial byte
        do_start();
        for (int i = 7; i >= 4; i--) begin
            ser_data = i[0];
            ser_clk = 1'b0; tick(3);
            ser_clk = 1'b1; tick(3);
        end
        ser_clk = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst.mid");
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        send_byte(8'h5A, 1'b1);
        check_all("rst.fresh");
        chk("rst.fresh1", fifo_count, 1);

        // Drain the prefilled byte, then the A5/3C session
        do_start();
        consume();
        do_done();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b0);
        do_start();
        chk("t2.head", prog_data, 8'hA5);
        consume();
        chk("t2.second", prog_data, 8'h3C);
        consume();
        consume();
        chk("t2.empty", prog_data, 8'h00);
        chk("t2.sent", bytes_sent, 2);

        // Full 16-byte session with randomised interleaving of sends and consumes
        do_done();
        do_start();
        nxt = 0;
        while (nxt < 16 || m_q.size() > 0) begin
            if (nxt < 16 && (m_q.size() == 0 || (m_q.size() < 3 && $urandom_range(1, 0) == 1))) begin
                send_byte(8'(nxt), 1'b0);
                nxt++;
            end else begin
                consume();
            end
        end
        chk("t3.sent", bytes_sent, 16);
        chk("t3.busy", busy, 1);
        do_done();
        chk("t3.run", programming, 0);

        // Overflow, then push+pop on a full FIFO
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 0);
        check_all("t4.ovf");
        chk("t4.ovf1", overflow, 1);
        chk("t4.cnt4", fifo_count, 4);
        do_start();
        cpu_ready = 1'b1;
        tick(2);
        check_all("t4.rdy");
        send_pop(8'($urandom));
        check_all("t4.pp");
        chk("t4.pp.cnt", fifo_count, 4);
        chk("t4.pp.ovf", overflow, 0);

        // Underrun, ignored start while busy, restart from RUN
        for (int i = 0; i < 5; i++) consume();
        chk("t5.und", underrun, 1);
        chk("t5.prog", prog_data, 8'h00);
        do_start();
        chk("t5.ign", bytes_sent, 5);
        do_done();
        do_start();
        chk("t5.clr", underrun, 0);

        // Early cpu_done after 5 bytes
        for (int i = 0; i < 5; i++) begin
            send_byte(8'($urandom), 1'b0);
            consume();
        end
        do_done();
        chk("t6.run", programming, 0);
        chk("t6.sent", bytes_sent, 5);

        // Random mix of operations
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(19, 0)) inside
                [0:6]:   send_byte(8'($urandom), m_q.size() < 4);
                [7:13]:  consume();
                [14:16]: do_start();
                default: do_done();
            endcase
            check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
